wl_group_rx: RTL

- Receiver end of the V1 WL time-multiplexed pin protocol: data[7:0] + group_sel[2:0] + latch, 12 pads carrying 64 WLs as 8 groups.
- Sits on the CIM/DAC side of the pad ring. Deserializes groups into a 64-bit shadow vector, then commits the full vector to an active WL register.
- Hands the active vector to the DAC front end with a valid/ack handshake.
- Flags protocol errors (duplicate group, overrun) in sticky status bits.

---
 rtl/wl_group_rx.sv | 116 +++++++++++
 1 files changed

// File: rtl/wl_group_rx.sv
// Receiver for the time-multiplexed WL pin protocol: collects groups into a
// shadow vector, then commits whole frames to wl_o under a valid/ack handshake.
module wl_group_rx #(
    parameter  int WL_GROUP_WIDTH = 8,
    parameter  int WL_GROUP_COUNT = 8,
    localparam int NUM_INPUTS     = WL_GROUP_WIDTH * WL_GROUP_COUNT,
    localparam int SEL_W          = $clog2(WL_GROUP_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WL_GROUP_WIDTH-1:0] wl_data_i,
    input  logic [SEL_W-1:0]          wl_group_sel_i,
    input  logic                      wl_latch_i,
    input  logic                      frame_clr_i,
    input  logic                      err_clr_i,
    input  logic                      wl_ack_i,
    output logic [NUM_INPUTS-1:0]     wl_o,
    output logic                      wl_valid_o,
    output logic [WL_GROUP_COUNT-1:0] group_mask_o,
    output logic                      dup_err_o,
    output logic                      overrun_o
);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t                    state_q, state_d;
    logic                      latch_q, latch_d;
    logic [NUM_INPUTS-1:0]     shadow_q, shadow_d;
    logic [NUM_INPUTS-1:0]     wl_q, wl_d;
    logic [WL_GROUP_COUNT-1:0] mask_q, mask_d;
    logic                      valid_q, valid_d;
    logic                      dup_q, dup_d;
    logic                      ovr_q, ovr_d;

    logic latch_edge, sel_ok, dup_set, ovr_set, xfer;

    assign latch_edge = wl_latch_i & ~latch_q;
    // Only reachable when the group count is not a power of two.
    assign sel_ok     = 32'(wl_group_sel_i) < WL_GROUP_COUNT;

    always_comb begin
        latch_d  = wl_latch_i;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        state_d  = state_q;
        wl_d     = wl_q;
        valid_d  = valid_q;
        dup_set  = 1'b0;
        ovr_set  = 1'b0;
        xfer     = 1'b0;

        if (frame_clr_i) begin
            mask_d  = '0;
            state_d = COLLECT;
        end else if (state_q == COLLECT) begin
            if (latch_edge) begin
                if (!sel_ok) begin
                    dup_set = 1'b1;
                end else begin
                    for (int g = 0; g < WL_GROUP_COUNT; g++) begin
                        if (wl_group_sel_i == SEL_W'(g)) begin
                            shadow_d[g*WL_GROUP_WIDTH +: WL_GROUP_WIDTH] = wl_data_i;
                            dup_set   = mask_q[g];
                            mask_d[g] = 1'b1;
                        end
                    end
                    if (&mask_d) state_d = FULL;
                end
            end
        end else begin
            ovr_set = latch_edge;
            if (!valid_q || wl_ack_i) begin
                xfer    = 1'b1;
                wl_d    = shadow_q;
                mask_d  = '0;
                state_d = COLLECT;
            end
        end

        // A transfer in the ack cycle keeps valid high with the new frame.
        if (xfer)          valid_d = 1'b1;
        else if (wl_ack_i) valid_d = 1'b0;

        dup_d = (dup_q & ~err_clr_i) | dup_set;
        ovr_d = (ovr_q & ~err_clr_i) | ovr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            latch_q  <= 1'b0;
            shadow_q <= '0;
            mask_q   <= '0;
            wl_q     <= '0;
            valid_q  <= 1'b0;
            dup_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            latch_q  <= latch_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            wl_q     <= wl_d;
            valid_q  <= valid_d;
            dup_q    <= dup_d;
            ovr_q    <= ovr_d;
        end
    end

    assign wl_o         = wl_q;
    assign wl_valid_o   = valid_q;
    assign group_mask_o = mask_q;
    assign dup_err_o    = dup_q;
    assign overrun_o    = ovr_q;

endmodule
